clock_group_reset_sequencer: RTL and testbench
==============================================

CLOCK_GROUP_RESET_SEQUENCER -- requirements
Module: clock_group_reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_MEMBERS, default 5: number of clock-group members (range 1..32).
REQ-002 SHALL have parameter CNT_W, default 8: width of cfg_hold and of the internal counters.
REQ-003 SHALL have parameter ASSERT_CYCLES, default 4: cycles member resets are held with clocks enabled (range 1..2^CNT_W-1).
REQ-004 SHALL have parameter GATE_CYCLES, default 2: cycles a re-reset member's clock is gated (range 1..2^CNT_W-1).
REQ-005 clock  in  1  sole block clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-low block reset.
REQ-007 cfg_hold  in  CNT_W  stagger between successive member releases, minus one.
REQ-008 sw_reset_req_valid  in  1  software re-reset request.
REQ-009 sw_reset_req_mask  in  NUM_MEMBERS  members to re-reset.
REQ-010 sw_reset_req_ready  out  1  request accepted when valid and ready are both high at a rising edge.
REQ-011 member_reset_out  out  NUM_MEMBERS  per-member reset, active-high.
REQ-012 member_clock_en  out  NUM_MEMBERS  per-member clock-gate enable.
REQ-013 seq_done  out  1  high while all members run out of reset.

Function
REQ-014 All outputs SHALL be registered.
REQ-015 FSM states SHALL be ASSERT, RELEASE, RUN, GATE and SWRST.
REQ-016 ASSERT: all member_reset_out=1, all member_clock_en=1, for ASSERT_CYCLES edges counted from the first edge with reset high; then RELEASE.
REQ-017 RELEASE: cfg_hold SHALL be sampled on the ASSERT->RELEASE edge; later cfg_hold changes SHALL be ignored until the next RELEASE.
REQ-018 Member k SHALL deassert its reset at edge ASSERT_CYCLES + k*(cfg_hold+1), in ascending index order.
REQ-019 cfg_hold=0 SHALL release one member per cycle.
REQ-020 One edge after the last member's release, the FSM SHALL enter RUN, with seq_done=1 and sw_reset_req_ready=1.
REQ-021 sw_reset_req_ready SHALL be 1 only in RUN; valid while ready=0 SHALL be ignored, not queued.
REQ-022 A handshake with all-zero mask SHALL be accepted as a no-op (stay RUN, outputs unchanged).
REQ-023 At handshake edge t with nonzero mask: mask latched; masked members member_reset_out=1 and member_clock_en=0; ready=0; seq_done=0; enter GATE.
REQ-024 Unmasked members SHALL be unaffected throughout GATE and SWRST.
REQ-025 At edge t+GATE_CYCLES: masked member_clock_en=1, resets still held; enter SWRST.
REQ-026 At edge t+GATE_CYCLES+ASSERT_CYCLES: masked resets deassert simultaneously; ready=1, seq_done=1; enter RUN.
REQ-027 NUM_MEMBERS=1 SHALL behave identically, with release at edge ASSERT_CYCLES and cfg_hold irrelevant.
REQ-028 Counters SHALL saturate, never wrap, and SHALL be sized so that no parameter in range overflows.

Reset
REQ-029 While reset=0 at a rising edge, next-state values SHALL be: state ASSERT, counters 0, member_reset_out all 1, member_clock_en all 0, seq_done 0, sw_reset_req_ready 0.
REQ-030 reset=0 in any state, including mid-RELEASE or mid-SWRST, SHALL apply REQ-029 at that edge and discard the latched mask.
REQ-031 Inputs SHALL be ignored while reset=0.

Verification (NUM_MEMBERS=5, ASSERT_CYCLES=4, GATE_CYCLES=2, CNT_W=8)
REQ-032 Power-up, cfg_hold=3: member_reset_out bits 0..4 fall at edges 4, 8, 12, 16, 20; seq_done and ready rise at edge 21; clock_en all 1 from edge 0.
REQ-033 cfg_hold=0: members release at edges 4, 5, 6, 7, 8; seq_done at 9. cfg_hold changed to 9 at edge 6: timing unchanged.
REQ-034 In RUN, mask=5'b00101 accepted at t:
- bits 0,2: clock_en=0 at t, clock_en=1 at t+2, reset=0 at t+6; ready and seq_done rise at t+6.
- bits 1,3,4 constant.
REQ-035 In RUN, mask=0 accepted: no output change. Valid held high during GATE: no second acceptance until ready returns; then accepted on the first edge with ready=1.
REQ-036 reset=0 asserted at edge 14 (mid-RELEASE) and at t+3 (mid-SWRST): outputs match REQ-029 at that edge; after release, the full sequence of REQ-032 repeats.

Source files
------------

// File: rtl/clock_group_reset_sequencer.sv
// Clock-group reset sequencer: staggered power-up release of member resets
// and software-requested re-reset with a clock-gated quiet period.
module clock_group_reset_sequencer #(
  parameter int NUM_MEMBERS   = 5,
  parameter int CNT_W         = 8,
  parameter int ASSERT_CYCLES = 4,
  parameter int GATE_CYCLES   = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       cfg_hold,
  input  logic                   sw_reset_req_valid,
  input  logic [NUM_MEMBERS-1:0] sw_reset_req_mask,
  output logic                   sw_reset_req_ready,
  output logic [NUM_MEMBERS-1:0] member_reset_out,
  output logic [NUM_MEMBERS-1:0] member_clock_en,
  output logic                   seq_done
);

  localparam int IDX_W = $clog2(NUM_MEMBERS + 1);

  localparam logic [CNT_W-1:0] A_END  = CNT_W'(ASSERT_CYCLES);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GATE_CYCLES - 1);

  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(NUM_MEMBERS);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  localparam logic [NUM_MEMBERS-1:0] BIT0 = NUM_MEMBERS'(1);

  typedef enum logic [2:0] {
    ASSERT,
    RELEASE,
    RUN,
    GATE,
    SWRST
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_inc;
  logic [CNT_W-1:0]       hold_q;
  logic [IDX_W-1:0]       idx;
  logic [NUM_MEMBERS-1:0] mask_q;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state              <= ASSERT;
      cnt                <= '0;
      hold_q             <= '0;
      idx                <= '0;
      mask_q             <= '0;
      member_reset_out   <= '1;
      member_clock_en    <= '0;
      seq_done           <= 1'b0;
      sw_reset_req_ready <= 1'b0;
    end else begin
      unique case (state)
        ASSERT: begin
          member_clock_en <= '1;
          if (cnt == A_END) begin
            state            <= RELEASE;
            hold_q           <= cfg_hold;
            cnt              <= '0;
            idx              <= IDX_ONE;
            member_reset_out <= member_reset_out & ~BIT0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RELEASE: begin
          if (idx == IDX_END) begin
            state              <= RUN;
            seq_done           <= 1'b1;
            sw_reset_req_ready <= 1'b1;
          end else if (cnt == hold_q) begin
            member_reset_out <= member_reset_out & ~(BIT0 << idx);
            idx              <= idx + IDX_ONE;
            cnt              <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RUN: begin
          // an all-zero mask completes the handshake without side effects
          if (sw_reset_req_valid && sw_reset_req_ready &&
              |sw_reset_req_mask) begin
            state              <= GATE;
            mask_q             <= sw_reset_req_mask;
            member_reset_out   <= member_reset_out | sw_reset_req_mask;
            member_clock_en    <= member_clock_en & ~sw_reset_req_mask;
            sw_reset_req_ready <= 1'b0;
            seq_done           <= 1'b0;
            cnt                <= '0;
          end
        end
        GATE: begin
          if (cnt == G_LAST) begin
            state           <= SWRST;
            member_clock_en <= member_clock_en | mask_q;
            cnt             <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SWRST: begin
          if (cnt == A_LAST) begin
            state              <= RUN;
            member_reset_out   <= member_reset_out & ~mask_q;
            sw_reset_req_ready <= 1'b1;
            seq_done           <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: state <= ASSERT;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Bench for clock_group_reset_sequencer: directed checkpoint table plus
// randomized traffic against an edge-time reference model.
module tb_clock_group_reset_sequencer;

  localparam int N = 5;
  localparam int A = 4;
  localparam int G = 2;
  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] hold;
  logic         vld;
  logic [N-1:0] msk;
  logic         rdy;
  logic [N-1:0] rst_o;
  logic [N-1:0] en_o;
  logic         done;

  logic         one_vld;
  logic [0:0]   one_msk;
  logic         one_rdy;
  logic [0:0]   one_rst;
  logic [0:0]   one_en;
  logic         one_done;

  int errors;
  int checks;

  clock_group_reset_sequencer #(
    .NUM_MEMBERS(N), .CNT_W(W),
    .ASSERT_CYCLES(A), .GATE_CYCLES(G)
  ) u_dut (
    .clock(clk),
    .reset(rst_n),
    .cfg_hold(hold),
    .sw_reset_req_valid(vld),
    .sw_reset_req_mask(msk),
    .sw_reset_req_ready(rdy),
    .member_reset_out(rst_o),
    .member_clock_en(en_o),
    .seq_done(done)
  );

  clock_group_reset_sequencer #(
    .NUM_MEMBERS(1), .CNT_W(W),
    .ASSERT_CYCLES(A), .GATE_CYCLES(G)
  ) u_one (
    .clock(clk),
    .reset(rst_n),
    .cfg_hold(hold),
    .sw_reset_req_valid(one_vld),
    .sw_reset_req_mask(one_msk),
    .sw_reset_req_ready(one_rdy),
    .member_reset_out(one_rst),
    .member_clock_en(one_en),
    .seq_done(one_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: outputs are derived from edge times since boot
  // and since the last accepted software request
  int           m_edge;
  int           m_boot;
  int           m_h;
  bit           m_sw;
  int           m_sw_t;
  logic [N-1:0] m_sw_m;
  logic [N-1:0] x_rst;
  logic [N-1:0] x_en;
  logic         x_done;
  logic         x_rdy;

  task automatic model_edge();
    int rel;
    int run_at;
    m_edge++;
    if (!rst_n) begin
      m_boot = -1;
      m_sw   = 0;
      x_rst  = '1;
      x_en   = '0;
      x_done = 1'b0;
      x_rdy  = 1'b0;
    end else begin
      if (m_boot < 0) m_boot = m_edge;
      rel = m_edge - m_boot;
      if (rel == A) m_h = int'(hold);
      run_at = A + (N - 1) * (m_h + 1) + 1;
      if (rel < A) begin
        x_rst  = '1;
        x_en   = '1;
        x_done = 1'b0;
        x_rdy  = 1'b0;
      end else if (rel < run_at) begin
        for (int k = 0; k < N; k++)
          x_rst[k] = (rel < A + k * (m_h + 1));
        x_en   = '1;
        x_done = 1'b0;
        x_rdy  = 1'b0;
      end else begin
        if (!m_sw && x_rdy && vld && msk != '0) begin
          m_sw   = 1;
          m_sw_t = m_edge;
          m_sw_m = msk;
        end
        if (m_sw && (m_edge - m_sw_t) >= G + A) m_sw = 0;
        if (m_sw) begin
          x_rst  = m_sw_m;
          x_en   = ((m_edge - m_sw_t) < G) ? ~m_sw_m : '1;
          x_done = 1'b0;
          x_rdy  = 1'b0;
        end else begin
          x_rst  = '0;
          x_en   = '1;
          x_done = 1'b1;
          x_rdy  = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b",
               name, $time, act[N-1:0], exp[N-1:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("model_rst", 32'(rst_o), 32'(x_rst));
    chk("model_en", 32'(en_o), 32'(x_en));
    chk("model_done", 32'(done), 32'(x_done));
    chk("model_rdy", 32'(rdy), 32'(x_rdy));
  endtask

  typedef struct {
    int           n;
    logic         rst;
    logic [W-1:0] hold;
    logic         vld;
    logic [N-1:0] msk;
    logic [N-1:0] e_rst;
    logic [N-1:0] e_en;
    logic         e_done;
    logic         e_rdy;
    logic         o_rst;
    logic         o_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input int h,
                     input logic v, input logic [N-1:0] m,
                     input logic [N-1:0] er, input logic [N-1:0] ee,
                     input logic ed, input logic ey,
                     input logic orr, input logic od);
    vec_t t;
    t.n = n; t.rst = r; t.hold = W'(h); t.vld = v; t.msk = m;
    t.e_rst = er; t.e_en = ee; t.e_done = ed; t.e_rdy = ey;
    t.o_rst = orr; t.o_done = od;
    tbl.push_back(t);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    m_edge  = 0;
    m_boot  = -1;
    m_h     = 0;
    m_sw    = 0;
    m_sw_t  = 0;
    m_sw_m  = '0;
    x_rst   = '1;
    x_en    = '0;
    x_done  = 1'b0;
    x_rdy   = 1'b0;
    rst_n   = 1'b0;
    hold    = '0;
    vld     = 1'b0;
    msk     = '0;
    one_vld = 1'b0;
    one_msk = '0;

    // power-up with cfg_hold=3
    add(2, 0, 3, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 1, 0);
    add(1, 1, 3, 0, 5'b00000, 5'b11111, 5'b11111, 0, 0, 1, 0);
    add(4, 1, 3, 0, 5'b00000, 5'b11110, 5'b11111, 0, 0, 0, 0);
    add(1, 1, 3, 0, 5'b00000, 5'b11110, 5'b11111, 0, 0, 0, 1);
    add(3, 1, 3, 0, 5'b00000, 5'b11100, 5'b11111, 0, 0, 0, 1);
    add(12, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    // software re-reset of members 0 and 2
    add(1, 1, 3, 1, 5'b00101, 5'b00101, 5'b11010, 0, 0, 0, 1);
    add(1, 1, 3, 0, 5'b00000, 5'b00101, 5'b11010, 0, 0, 0, 1);
    add(1, 1, 3, 0, 5'b00000, 5'b00101, 5'b11111, 0, 0, 0, 1);
    add(3, 1, 3, 0, 5'b00000, 5'b00101, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    // zero mask is a no-op
    add(1, 1, 3, 1, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    add(2, 1, 3, 1, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    // valid held through GATE/SWRST
    add(1, 1, 3, 1, 5'b10000, 5'b10000, 5'b01111, 0, 0, 0, 1);
    add(5, 1, 3, 1, 5'b00010, 5'b10000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 3, 1, 5'b00010, 5'b00000, 5'b11111, 1, 1, 0, 1);
    add(1, 1, 3, 1, 5'b00010, 5'b00010, 5'b11101, 0, 0, 0, 1);
    add(2, 1, 3, 0, 5'b00000, 5'b00010, 5'b11111, 0, 0, 0, 1);
    // reset mid-SWRST, then full reboot
    add(1, 0, 3, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 1, 0);
    add(1, 1, 3, 0, 5'b00000, 5'b11111, 5'b11111, 0, 0, 1, 0);
    add(20, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    // cfg_hold=0, changed to 9 after sampling
    add(1, 0, 0, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 1, 0);
    add(5, 1, 0, 0, 5'b00000, 5'b11110, 5'b11111, 0, 0, 0, 0);
    add(2, 1, 9, 0, 5'b00000, 5'b11000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 9, 0, 5'b00000, 5'b10000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 9, 0, 5'b00000, 5'b00000, 5'b11111, 0, 0, 0, 1);
    add(1, 1, 9, 0, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);
    // reset at edge 14 of a cfg_hold=3 boot
    add(1, 0, 3, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 1, 0);
    add(14, 1, 3, 0, 5'b00000, 5'b11000, 5'b11111, 0, 0, 0, 1);
    add(1, 0, 3, 0, 5'b00000, 5'b11111, 5'b00000, 0, 0, 1, 0);
    add(22, 1, 3, 0, 5'b00000, 5'b00000, 5'b11111, 1, 1, 0, 1);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      hold  = tbl[i].hold;
      vld   = tbl[i].vld;
      msk   = tbl[i].msk;
      for (int c = 0; c < tbl[i].n; c++) step();
      chk($sformatf("vec%0d_rst", i), 32'(rst_o), 32'(tbl[i].e_rst));
      chk($sformatf("vec%0d_en", i), 32'(en_o), 32'(tbl[i].e_en));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].e_done));
      chk($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_one_rst", i), 32'(one_rst),
          32'(tbl[i].o_rst));
      chk($sformatf("vec%0d_one_done", i), 32'(one_done),
          32'(tbl[i].o_done));
      chk($sformatf("vec%0d_one_rdy", i), 32'(one_rdy),
          32'(tbl[i].o_done));
      chk($sformatf("vec%0d_one_en", i), 32'(one_en),
          32'(tbl[i].rst));
    end

    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 9) == 0) hold = W'($urandom_range(0, 4));
      vld = ($urandom_range(0, 3) == 0);
      msk = N'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
